// File: rtl/fir_loader.sv
// Coefficient/sample loader for a FIR ALU stage: loads NTAP coefficients onto b,
// then streams NSAMP samples through a show-ahead FIFO. Optional feature: LD_CHECKSUM_EN.
module fir_loader #(
   parameter int NTAP   = 64,
   parameter int NSAMP  = 10000,
   parameter int FDEPTH = 8
) (
   input  logic               clk1,
   input  logic               LD_restn,
   input  logic               start,
   input  logic signed [15:0] din,
   input  logic               din_valid,
   output logic               din_ready,
   output logic signed [15:0] b,
   output logic               b_valid,
   output logic               b_strobe,
   output logic signed [15:0] x,
   output logic               x_valid,
   input  logic               x_ready,
   output logic               coef_done,
   output logic [13:0]        samp_cnt,
   output logic               coef_err
);

   localparam int TAP_W = (NTAP > 1) ? $clog2(NTAP) : 1;
   localparam int PTR_W = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [TAP_W-1:0] TAP_LAST  = TAP_W'(NTAP - 1);
   localparam logic [13:0]      SAMP_MAX  = 14'(NSAMP);
   localparam logic [13:0]      SAMP_LAST = 14'(NSAMP - 1);
   localparam logic [CNT_W-1:0] FIFO_MAX  = CNT_W'(FDEPTH);

   typedef enum logic [2:0] {
      IDLE,
      COEF,
`ifdef LD_CHECKSUM_EN
      CHK,
`endif
      RUN,
      DRAIN,
      DONE
   } state_t;

   state_t state_reg, state_next;

   logic [TAP_W-1:0]  tap_cnt_reg;
   logic [13:0]       samp_cnt_reg;
   logic              coef_done_reg;
   logic signed [15:0] b_reg;
   logic              b_strobe_reg;

   logic [PTR_W-1:0]  wr_ptr_reg;
   logic [PTR_W-1:0]  rd_ptr_reg;
   logic [CNT_W-1:0]  count_reg;
   logic signed [15:0] mem_reg [FDEPTH];
   logic [FDEPTH-1:0] slot_we;

   logic fifo_full;
   logic fifo_empty;
   logic start_accept;
   logic chk_fail;
   logic coef_xfer;
   logic push;
   logic pop;

`ifdef LD_CHECKSUM_EN
   logic [15:0] sum_reg;
   logic        coef_err_reg;
`endif

   assign fifo_full  = (count_reg == FIFO_MAX);
   assign fifo_empty = (count_reg == '0);

   always_comb begin
      state_next   = state_reg;
      din_ready    = 1'b0;
      start_accept = 1'b0;
      chk_fail     = 1'b0;
      case (state_reg)
         IDLE, DONE: begin
            if (start) begin
               state_next   = COEF;
               start_accept = 1'b1;
            end
         end
         COEF: begin
            din_ready = 1'b1;
            if (din_valid && tap_cnt_reg == TAP_LAST) begin
`ifdef LD_CHECKSUM_EN
               state_next = CHK;
`else
               state_next = RUN;
`endif
            end
         end
`ifdef LD_CHECKSUM_EN
         CHK: begin
            // The word following the last coefficient is the expected wrapping sum.
            din_ready = 1'b1;
            if (din_valid) begin
               if (sum_reg == din) begin
                  state_next = RUN;
               end else begin
                  state_next = IDLE;
                  chk_fail   = 1'b1;
               end
            end
         end
`endif
         RUN: begin
            din_ready = !fifo_full && (samp_cnt_reg < SAMP_MAX);
            if (din_valid && din_ready && samp_cnt_reg == SAMP_LAST) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (fifo_empty) begin
               state_next = DONE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign coef_xfer = din_valid && din_ready && (state_reg == COEF);
   assign push      = din_valid && din_ready && (state_reg == RUN);
   assign pop       = x_valid && x_ready;

   always_ff @(posedge clk1 or negedge LD_restn) begin
      if (!LD_restn) begin
         state_reg     <= IDLE;
         tap_cnt_reg   <= '0;
         samp_cnt_reg  <= '0;
         coef_done_reg <= 1'b0;
         b_reg         <= '0;
         b_strobe_reg  <= 1'b0;
      end else begin
         state_reg    <= state_next;
         b_strobe_reg <= coef_xfer;
         if (coef_xfer) begin
            b_reg <= din;
         end
         if (start_accept) begin
            tap_cnt_reg   <= '0;
            samp_cnt_reg  <= '0;
            coef_done_reg <= 1'b0;
         end else begin
            if (coef_xfer) begin
               tap_cnt_reg <= tap_cnt_reg + 1'b1;
               if (tap_cnt_reg == TAP_LAST) begin
                  coef_done_reg <= 1'b1;
               end
            end
            if (chk_fail) begin
               coef_done_reg <= 1'b0;
            end
            if (push) begin
               samp_cnt_reg <= samp_cnt_reg + 1'b1;
            end
         end
      end
   end

`ifdef LD_CHECKSUM_EN
   always_ff @(posedge clk1 or negedge LD_restn) begin
      if (!LD_restn) begin
         sum_reg      <= '0;
         coef_err_reg <= 1'b0;
      end else if (start_accept) begin
         sum_reg      <= '0;
         coef_err_reg <= 1'b0;
      end else begin
         if (coef_xfer) begin
            sum_reg <= sum_reg + $unsigned(din);
         end
         if (chk_fail) begin
            coef_err_reg <= 1'b1;
         end
      end
   end

   assign coef_err = coef_err_reg;
`else
   assign coef_err = 1'b0;
`endif

   // Storage is cleared on reset so the empty FIFO presents x = 0.
   generate
      for (genvar gi = 0; gi < FDEPTH; gi++) begin : g_slot_we
         assign slot_we[gi] = push && (wr_ptr_reg == PTR_W'(gi));
      end
   endgenerate

   always_ff @(posedge clk1 or negedge LD_restn) begin
      if (!LD_restn) begin
         for (int i = 0; i < FDEPTH; i++) begin
            mem_reg[i] <= '0;
         end
      end else begin
         for (int i = 0; i < FDEPTH; i++) begin
            if (slot_we[i]) begin
               mem_reg[i] <= din;
            end
         end
      end
   end

   always_ff @(posedge clk1 or negedge LD_restn) begin
      if (!LD_restn) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign x         = mem_reg[rd_ptr_reg];
   assign x_valid   = !fifo_empty;
   assign b         = b_reg;
   assign b_strobe  = b_strobe_reg;
   assign b_valid   = (state_reg == RUN) || (state_reg == DRAIN);
   assign coef_done = coef_done_reg;
   assign samp_cnt  = samp_cnt_reg;

endmodule

// File: tb/tb_fir_loader.sv
// Directed bench for fir_loader (NTAP=64, NSAMP=16, FDEPTH=8); covers LD_CHECKSUM_EN when defined.
module tb_fir_loader;

   localparam int NTAP   = 64;
   localparam int NSAMP  = 16;
   localparam int FDEPTH = 8;

   logic        clk1 = 1'b0;
   logic        LD_restn = 1'b0;
   logic        start = 1'b0;
   logic [15:0] din = '0;
   logic        din_valid = 1'b0;
   logic        x_ready = 1'b0;
   logic        din_ready;
   logic [15:0] b;
   logic        b_valid;
   logic        b_strobe;
   logic [15:0] x;
   logic        x_valid;
   logic        coef_done;
   logic [13:0] samp_cnt;
   logic        coef_err;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] q[$];
   int          model_samp = 0;
   logic [15:0] next_val = 16'h0100;

   fir_loader #(.NTAP(NTAP), .NSAMP(NSAMP), .FDEPTH(FDEPTH)) dut (
      .clk1      (clk1),
      .LD_restn  (LD_restn),
      .start     (start),
      .din       (din),
      .din_valid (din_valid),
      .din_ready (din_ready),
      .b         (b),
      .b_valid   (b_valid),
      .b_strobe  (b_strobe),
      .x         (x),
      .x_valid   (x_valid),
      .x_ready   (x_ready),
      .coef_done (coef_done),
      .samp_cnt  (samp_cnt),
      .coef_err  (coef_err)
   );

   always #5 clk1 = ~clk1;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk1);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      $display("reset check %s", tag);
      chk1 ({tag, ".din_ready"}, din_ready, 1'b0);
      chk16({tag, ".b"},         b,         16'h0000);
      chk1 ({tag, ".b_strobe"},  b_strobe,  1'b0);
      chk1 ({tag, ".b_valid"},   b_valid,   1'b0);
      chk1 ({tag, ".x_valid"},   x_valid,   1'b0);
      chk16({tag, ".x"},         x,         16'h0000);
      chk1 ({tag, ".coef_done"}, coef_done, 1'b0);
      chk16({tag, ".samp_cnt"},  {2'b00, samp_cnt}, 16'd0);
      chk1 ({tag, ".coef_err"},  coef_err,  1'b0);
   endtask

   // Coefficient i is base + step*i; sum_err is added to the checksum word.
   task automatic load_coefs(input logic [15:0] base, input logic [15:0] step,
                             input logic [15:0] sum_err);
      logic [15:0] v;
      logic [15:0] sum;
      sum = '0;
      for (int i = 0; i < NTAP; i++) begin
         v = base + step * 16'(i);
         sum = sum + v;
         din = v;
         din_valid = 1'b1;
         chk1("coef_din_ready", din_ready, 1'b1);
         tick();
         chk16("coef_b", b, v);
         chk1("coef_b_strobe", b_strobe, 1'b1);
      end
      chk1("coef_done_after_last", coef_done, 1'b1);
`ifdef LD_CHECKSUM_EN
      chk1("chk_din_ready", din_ready, 1'b1);
      chk1("chk_b_valid", b_valid, 1'b0);
      din = sum + sum_err;
      tick();
      chk1("chk_no_strobe", b_strobe, 1'b0);
`endif
      din_valid = 1'b0;
      din = '0;
      $display("coef load base=%04h step=%04h checksum_word=%04h", base, step, sum + sum_err);
   endtask

   task automatic model_clear();
      q.delete();
      model_samp = 0;
   endtask

   // One RUN/DRAIN/DONE cycle against a FIFO scoreboard.
   task automatic samp_step(input logic dv, input logic xr);
      logic exp_ready;
      din_valid = dv;
      x_ready = xr;
      din = next_val;
      exp_ready = (q.size() < FDEPTH) && (model_samp < NSAMP);
      chk1("samp_din_ready", din_ready, exp_ready);
      chk1("samp_x_valid", x_valid, q.size() > 0);
      if (q.size() > 0) chk16("samp_x", x, q[0]);
      tick();
      if (q.size() > 0 && xr) begin
         $display("pop x=%04h", q[0]);
         void'(q.pop_front());
      end
      if (exp_ready && dv) begin
         $display("push din=%04h samp=%0d", next_val, model_samp + 1);
         q.push_back(next_val);
         model_samp++;
         next_val = next_val + 16'd1;
      end
   endtask

   initial begin
      // Reset state
      repeat (2) tick();
      check_reset_values("por");
      LD_restn = 1'b1;
      tick();
      chk1("idle_din_ready", din_ready, 1'b0);

      // din_valid in IDLE is not consumed
      din = 16'h0005;
      din_valid = 1'b1;
      tick();
      chk16("idle_b_hold", b, 16'h0000);
      chk1("idle_no_strobe", b_strobe, 1'b0);
      din_valid = 1'b0;

      // Coefficient load 1..64
      pulse_start();
      chk1("coef_state_ready", din_ready, 1'b1);
      chk1("coef_done_clear", coef_done, 1'b0);
      load_coefs(16'd1, 16'd1, 16'd0);
      tick();
      chk1("post_load_strobe", b_strobe, 1'b0);
      chk16("post_load_b_hold", b, 16'd64);
      chk1("run_b_valid", b_valid, 1'b1);
      chk1("run_coef_done", coef_done, 1'b1);
      chk1("run_coef_err", coef_err, 1'b0);

      // Fill FIFO with consumer stalled: 10 offered, 8 taken
      model_clear();
      for (int k = 0; k < 10; k++) samp_step(1'b1, 1'b0);
      din_valid = 1'b0;
      chk16("full_samp_cnt", {2'b00, samp_cnt}, 16'd8);
      chk16("full_x_head", x, 16'h0100);
      chk1("full_din_ready", din_ready, 1'b0);

      // start while RUN is ignored
      pulse_start();
      chk16("start_ign_samp_cnt", {2'b00, samp_cnt}, 16'd8);
      chk1("start_ign_b_valid", b_valid, 1'b1);
      chk1("start_ign_din_ready", din_ready, 1'b0);
      chk1("start_ign_coef_done", coef_done, 1'b1);

      // Stream with consumer running; NSAMP limit, drain, done
      for (int k = 0; k < 20; k++) samp_step(1'b1, 1'b1);
      din_valid = 1'b0;
      x_ready = 1'b0;
      chk16("done_samp_cnt", {2'b00, samp_cnt}, 16'd16);
      chk1("done_b_valid", b_valid, 1'b0);
      chk1("done_x_valid", x_valid, 1'b0);
      chk1("done_coef_done", coef_done, 1'b1);
      chk1("done_din_ready", din_ready, 1'b0);

      // New run from DONE, reset mid-run after 5 samples
      pulse_start();
      chk1("rerun_coef_done", coef_done, 1'b0);
      chk16("rerun_samp_cnt", {2'b00, samp_cnt}, 16'd0);
      chk1("rerun_din_ready", din_ready, 1'b1);
      chk1("rerun_b_valid", b_valid, 1'b0);
      load_coefs(16'h0010, 16'h0003, 16'd0);
      tick();
      chk1("rerun_run_b_valid", b_valid, 1'b1);
      model_clear();
      for (int k = 0; k < 5; k++) samp_step(1'b1, 1'b0);
      din_valid = 1'b0;
      chk16("mid_samp_cnt", {2'b00, samp_cnt}, 16'd5);
      chk1("mid_x_valid", x_valid, 1'b1);
      #2;
      LD_restn = 1'b0;
      #1;
      check_reset_values("async");
      tick();
      check_reset_values("held");
      LD_restn = 1'b1;
      tick();
      check_reset_values("release");
      pulse_start();
      load_coefs(16'hFFF0, 16'h0001, 16'd0);
      tick();
      chk1("reload_b_valid", b_valid, 1'b1);
      chk1("reload_coef_done", coef_done, 1'b1);
      chk16("reload_b_hold", b, 16'h002F);
      chk16("reload_samp_cnt", {2'b00, samp_cnt}, 16'd0);

`ifdef LD_CHECKSUM_EN
      // Checksum: 64 x 0x0400 wraps to 0x0000
      LD_restn = 1'b0;
      tick();
      LD_restn = 1'b1;
      tick();
      pulse_start();
      load_coefs(16'h0400, 16'h0000, 16'h0000);
      chk1("cks_ok_b_valid", b_valid, 1'b1);
      chk1("cks_ok_coef_err", coef_err, 1'b0);
      LD_restn = 1'b0;
      tick();
      LD_restn = 1'b1;
      tick();
      pulse_start();
      load_coefs(16'h0400, 16'h0000, 16'h0001);
      chk1("cks_bad_coef_err", coef_err, 1'b1);
      chk1("cks_bad_coef_done", coef_done, 1'b0);
      chk1("cks_bad_din_ready", din_ready, 1'b0);
      chk1("cks_bad_b_valid", b_valid, 1'b0);
      tick();
      chk1("cks_bad_sticky", coef_err, 1'b1);
      pulse_start();
      chk1("cks_start_clears_err", coef_err, 1'b0);
      chk1("cks_start_coef_state", din_ready, 1'b1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fir_loader.md
FIR_LOADER -- requirements
Module: fir_loader

Interface
REQ-001 Parameter NTAP, 64, number of coefficients loaded per run.
REQ-002 Parameter NSAMP, 10000, number of samples accepted per run.
REQ-003 Parameter FDEPTH, 8, sample FIFO depth (power of two).
REQ-004 clk1  in  1  single clock; all state changes on rising edge.
REQ-005 LD_restn  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle pulse that begins a run; ignored outside IDLE/DONE.
REQ-007 din  in  16  signed input word (coefficient or sample).
REQ-008 din_valid  in  1  din is valid this cycle.
REQ-009 din_ready  out  1  loader accepts din this cycle; transfer = din_valid & din_ready.
REQ-010 b  out  16  signed coefficient to the ALU stage.
REQ-011 b_valid  out  1  high while the ALU stage may run (coefficients loaded, run active).
REQ-012 b_strobe  out  1  one-cycle pulse per new coefficient on b.
REQ-013 x  out  16  signed sample, FIFO head.
REQ-014 x_valid  out  1  FIFO non-empty.
REQ-015 x_ready  in  1  consumer takes x this cycle; pop = x_valid & x_ready.
REQ-016 coef_done  out  1  all NTAP coefficients delivered.
REQ-017 samp_cnt  out  14  samples accepted in current run.
REQ-018 coef_err  out  1  checksum mismatch flag (see Configuration).

Function
REQ-019 FSM states IDLE, COEF, CHK, RUN, DRAIN, DONE; SHALL be one-hot or binary, no other states reachable.
REQ-020 IDLE: din_ready=0; start -> COEF, clears tap counter, samp_cnt, coef_done, coef_err.
REQ-021 COEF: din_ready=1; each transfer registers din onto b and pulses b_strobe next cycle (latency 1); b holds last value between transfers.
REQ-022 COEF: tap counter increments per transfer; transfer with counter==NTAP-1 -> CHK (macro defined) or RUN (macro undefined), coef_done set same edge.
REQ-023 RUN: din_ready = !fifo_full && samp_cnt<NSAMP; each transfer pushes din and increments samp_cnt.
REQ-024 FIFO SHALL be show-ahead: x = head, x_valid = !empty; pushed word visible on x the cycle after push.
REQ-025 Simultaneous push and pop SHALL be allowed at any occupancy except push when full (blocked by din_ready); occupancy unchanged.
REQ-026 Pointers SHALL wrap modulo FDEPTH; occupancy counter 0..FDEPTH.
REQ-027 samp_cnt reaching NSAMP -> DRAIN; DRAIN: din_ready=0, pops continue; empty -> DONE.
REQ-028 b_valid SHALL be 1 in RUN and DRAIN only.
REQ-029 DONE: coef_done, samp_cnt held; start -> COEF (new run).
REQ-030 start while COEF/CHK/RUN/DRAIN SHALL have no effect.
REQ-031 din_valid with din_ready=0 SHALL not be consumed or counted.

Reset
REQ-032 LD_restn low SHALL immediately force IDLE, b=0, b_strobe=0, b_valid=0, FIFO empty (x_valid=0, x=0), coef_done=0, samp_cnt=0, coef_err=0, din_ready=0.
REQ-033 Reset asserted mid-run SHALL discard all FIFO contents and partial coefficient count; no output pulses on release.

Configuration
REQ-034 Macro LD_CHECKSUM_EN defined: 16-bit wrapping sum of all NTAP coefficients; CHK accepts one extra word (din_ready=1); equal -> RUN, unequal -> coef_err=1 (sticky until start/reset), coef_done cleared, -> IDLE.
REQ-035 LD_CHECKSUM_EN undefined: CHK state and adder absent, COEF -> RUN directly, coef_err tied 0.

Verification
REQ-036 Reset, start, 64 coefficients 1..64 back-to-back -> b_strobe 64 pulses, b follows din by 1 cycle, coef_done=1 after 64th, b_valid=1.
REQ-037 RUN with x_ready=0, 10 samples offered -> 8 accepted, din_ready=0 at full, samp_cnt=8, x=first sample.
REQ-038 Full FIFO, x_ready=1, din_valid=1 continuous -> one push per pop after first pop, samples emerge in order, occupancy stays 7-8.
REQ-039 NSAMP=16 override, stream 20 samples -> exactly 16 accepted, DRAIN empties, DONE, b_valid=0, samp_cnt=16.
REQ-040 LD_CHECKSUM_EN: coefficients all 0x0400, checksum word 0x0000 -> RUN; checksum 0x0001 -> coef_err=1, IDLE.
REQ-041 LD_restn pulsed low after 5 samples in RUN -> all outputs at reset values next edge; new start reloads coefficients.
